// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - round-robin write-back arbiter for the register file write port
// Optional busy scoreboard enabled by defining REG_WB_SCOREBOARD_EN.
module reg_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  alloc_valid,
  input  logic [ADDR_WIDTH-1:0] alloc_addr,
  input  logic [ADDR_WIDTH-1:0] chk_addr1,
  input  logic [ADDR_WIDTH-1:0] chk_addr2,
  output logic                  chk_busy1,
  output logic                  chk_busy2
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic prio;
  logic both_valid;

  assign both_valid = req0_valid && req1_valid;
  assign req0_ready = req0_valid && (!req1_valid || !prio);
  assign req1_ready = req1_valid && (!req0_valid || prio);

  // Every contended cycle produces a grant, so the pointer simply flips.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio     <= 1'b0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (both_valid)
        prio <= ~prio;
      if (req0_ready) begin
        rf_wen   <= (req0_addr != '0);
        rf_waddr <= req0_addr;
        rf_wdata <= req0_data;
      end else if (req1_ready) begin
        rf_wen   <= (req1_addr != '0);
        rf_waddr <= req1_addr;
        rf_wdata <= req1_data;
      end else begin
        rf_wen <= 1'b0;
      end
    end
  end

`ifdef REG_WB_SCOREBOARD_EN
  logic [NREG-1:1] busy;
  logic [NREG-1:0] busy_full;

  assign busy_full = {busy, 1'b0};

  // A fresh allocation outranks the commit of the older writer to the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (alloc_valid && alloc_addr == ADDR_WIDTH'(i))
          busy[i] <= 1'b1;
        else if (rf_wen && rf_waddr == ADDR_WIDTH'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  assign chk_busy1 = busy_full[chk_addr1];
  assign chk_busy2 = busy_full[chk_addr2];
`else
  logic unused_sb;

  assign unused_sb = ^{alloc_valid, alloc_addr, chk_addr1, chk_addr2, NREG[0]};
  assign chk_busy1 = 1'b0;
  assign chk_busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - self-checking bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

`ifdef REG_WB_SCOREBOARD_EN
  localparam bit SB_ON = 1'b1;
`else
  localparam bit SB_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        alloc_valid;
  logic [4:0]  alloc_addr, chk_addr1, chk_addr2;
  logic        chk_busy1, chk_busy2;

  int n_tests = 0;
  int n_fail  = 0;

  reg_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        er0;
    logic        er1;
    logic        ewen;
    logic [4:0]  ewaddr;
    logic [31:0] ewdata;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic er0, input logic er1, input logic ewen,
                              input logic [4:0] ewaddr, input logic [31:0] ewdata);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.er0 = er0; v.er1 = er1; v.ewen = ewen; v.ewaddr = ewaddr; v.ewdata = ewdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
    alloc_valid = 1'b0; alloc_addr = 5'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model state for the randomized phase
  logic        m_prio, m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_sb;

  initial begin
    logic        h0, h1, eg0, eg1, n_wen, n_prio;
    logic [4:0]  n_waddr;
    logic [31:0] n_wdata, n_sb;
    logic        e_b1, e_b2;

    rst_n = 1'b0;
    idle_inputs();
    chk_addr1 = 5'd0; chk_addr2 = 5'd0;

    tbl[0] = mk(1'b1, 5'd5, 32'h1234,     1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd5, 32'h1234);
    tbl[1] = mk(1'b1, 5'd3, 32'hA,        1'b1, 5'd7, 32'hB,        1'b1, 1'b0, 1'b1, 5'd3, 32'hA);
    tbl[2] = mk(1'b1, 5'd3, 32'hA,        1'b1, 5'd7, 32'hB,        1'b0, 1'b1, 1'b1, 5'd7, 32'hB);
    tbl[3] = mk(1'b1, 5'd3, 32'hA,        1'b1, 5'd7, 32'hD,        1'b1, 1'b0, 1'b1, 5'd3, 32'hA);
    tbl[4] = mk(1'b1, 5'd3, 32'hC,        1'b1, 5'd7, 32'hD,        1'b0, 1'b1, 1'b1, 5'd7, 32'hD);
    tbl[5] = mk(1'b1, 5'd3, 32'hC,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd3, 32'hC);
    tbl[6] = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF);
    tbl[7] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF);
    tbl[8] = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 32'h55,       1'b0, 1'b1, 1'b1, 5'd2, 32'h55);
    tbl[9] = mk(1'b1, 5'd4, 32'h66,       1'b1, 5'd6, 32'h77,       1'b1, 1'b0, 1'b1, 5'd4, 32'h66);

    @(negedge clk);
    @(negedge clk);
    #1 check("reset_rf", {58'd0, rf_wen, rf_waddr}, 64'd0);
    check("reset_wdata", {32'd0, rf_wdata}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req0_valid = tbl[i].v0; req0_addr = tbl[i].a0; req0_data = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_addr = tbl[i].a1; req1_data = tbl[i].d1;
      #1 check($sformatf("tbl%0d_ready", i), {62'd0, req0_ready, req1_ready}, {62'd0, tbl[i].er0, tbl[i].er1});
      @(posedge clk);
      #1 check($sformatf("tbl%0d_rf", i), {26'd0, rf_wen, rf_waddr, rf_wdata},
               {26'd0, tbl[i].ewen, tbl[i].ewaddr, tbl[i].ewdata});
    end

    // prio is 1 here; a lone req0 grant keeps it, then reset must clear it
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b0;
    @(posedge clk);
    #1 check("pre_reset_wen", {63'd0, rf_wen}, 64'd1);
    #1 rst_n = 1'b0;
    #1 check("async_reset_rf", {26'd0, rf_wen, rf_waddr, rf_wdata}, 64'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h88;
    #1 check("prio_after_reset", {62'd0, req0_ready, req1_ready}, 64'd2);
    @(negedge clk);
    req0_valid = 1'b0;
    #1 check("req1_after_req0", {62'd0, req0_ready, req1_ready}, 64'd1);
    @(negedge clk);
    idle_inputs();

    // Scoreboard corner cases
    @(negedge clk);
    alloc_valid = 1'b1; alloc_addr = 5'd9; chk_addr1 = 5'd9; chk_addr2 = 5'd0;
    #1 check("sb_before_alloc", {63'd0, chk_busy1}, 64'd0);
    @(negedge clk);
    alloc_valid = 1'b0;
    #1 check("sb_after_alloc", {62'd0, chk_busy1, chk_busy2}, {62'd0, SB_ON, 1'b0});
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
    @(negedge clk);
    req0_valid = 1'b0;
    #1 check("sb_write_stage", {62'd0, rf_wen, chk_busy1}, {62'd0, 1'b1, SB_ON});
    @(negedge clk);
    #1 check("sb_after_commit", {63'd0, chk_busy1}, 64'd0);
    alloc_valid = 1'b1; alloc_addr = 5'd9;
    @(negedge clk);
    alloc_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h9A;
    @(negedge clk);
    req0_valid = 1'b0;
    alloc_valid = 1'b1; alloc_addr = 5'd9;
    @(negedge clk);
    alloc_valid = 1'b0; chk_addr2 = 5'd9;
    #1 check("sb_set_wins", {62'd0, chk_busy1, chk_busy2}, {62'd0, SB_ON, SB_ON});

    // Randomized run against the reference model
    do_reset();
    m_prio = 1'b0; m_wen = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0; m_sb = 32'd0;
    h0 = 1'b0; h1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!h0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        req0_data  = $urandom;
      end
      if (!h1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        req1_data  = $urandom;
      end
      alloc_valid = ($urandom_range(0, 1) != 0);
      alloc_addr  = 5'($urandom_range(0, 31));
      chk_addr1   = 5'($urandom_range(0, 31));
      chk_addr2   = ($urandom_range(0, 1) != 0) ? m_waddr : 5'($urandom_range(0, 31));
      #1;
      if (req0_valid && req1_valid) begin
        eg0 = !m_prio; eg1 = m_prio; n_prio = !m_prio;
      end else begin
        eg0 = req0_valid; eg1 = req1_valid; n_prio = m_prio;
      end
      check($sformatf("rnd%0d_ready", c), {62'd0, req0_ready, req1_ready}, {62'd0, eg0, eg1});
      e_b1 = SB_ON && (chk_addr1 != 5'd0) && m_sb[chk_addr1];
      e_b2 = SB_ON && (chk_addr2 != 5'd0) && m_sb[chk_addr2];
      check($sformatf("rnd%0d_busy", c), {62'd0, chk_busy1, chk_busy2}, {62'd0, e_b1, e_b2});
      n_sb = m_sb;
      if (m_wen) n_sb[m_waddr] = 1'b0;
      if (SB_ON && alloc_valid && alloc_addr != 5'd0) n_sb[alloc_addr] = 1'b1;
      n_wen = 1'b0; n_waddr = m_waddr; n_wdata = m_wdata;
      if (eg0) begin
        n_wen = (req0_addr != 5'd0); n_waddr = req0_addr; n_wdata = req0_data;
      end else if (eg1) begin
        n_wen = (req1_addr != 5'd0); n_waddr = req1_addr; n_wdata = req1_data;
      end
      h0 = req0_valid && !eg0;
      h1 = req1_valid && !eg1;
      @(posedge clk);
      m_prio = n_prio; m_wen = n_wen; m_waddr = n_waddr; m_wdata = n_wdata; m_sb = n_sb;
      #1 check($sformatf("rnd%0d_rf", c), {26'd0, rf_wen, rf_waddr, rf_wdata},
               {26'd0, m_wen, m_waddr, m_wdata});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-back arbiter for the 32-entry register file. Shares the file's single write port (`wen`/`waddr`/`wdata`) between two write-back requesters, the ALU path (req0) and the load path (req1), using a valid/ready handshake and round-robin priority. Drives the write port from registered outputs. Optionally keeps a per-register busy scoreboard that issue logic uses to detect pending writes.

## Interface
Parameters:
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register address width; the scoreboard covers 2**ADDR_WIDTH entries

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  ALU write-back request
- req0_addr  in  ADDR_WIDTH  destination register
- req0_data  in  DATA_WIDTH  write data
- req0_ready  out  1  grant to req0 (combinational)
- req1_valid / req1_addr / req1_data / req1_ready  same roles for the load path
- rf_wen  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_WIDTH  register-file write address (registered)
- rf_wdata  out  DATA_WIDTH  register-file write data (registered)
- alloc_valid  in  1  issue logic reserves a destination register
- alloc_addr  in  ADDR_WIDTH  register being reserved
- chk_addr1, chk_addr2  in  ADDR_WIDTH  source registers to check
- chk_busy1, chk_busy2  out  1  checked register has a pending write (combinational)

## Operation
- Handshake: a transfer occurs when `reqN_valid && reqN_ready` at a posedge.
  - Once `valid` is raised, the requester holds `valid`, `addr` and `data` stable until the transfer.
  - `ready` never depends on the same requester's `data`.
- Arbitration: at most one `ready` is high per cycle.
  - If only one requester is valid, it is granted.
  - If both are valid, the one selected by the 1-bit pointer `prio` is granted (0 selects req0).
  - After a both-valid grant to req i, `prio` points to the other requester.
  - A grant with only one requester valid leaves `prio` unchanged.
- No backpressure from the register file: a grant is issued every cycle in which some `valid` is high.
- Write stage: on a transfer, the granted `addr` and `data` are captured into `rf_waddr` and `rf_wdata`.
  - `rf_wen` is set to 1 only if `addr != 0`.
  - A write to x0 is accepted (ready=1) and then dropped: `rf_wen` is 0 the next cycle.
  - With no transfer, `rf_wen` is 0; `rf_waddr` and `rf_wdata` hold their values.
- Reset (asynchronous assert, synchronous deassert by the surrounding logic):
  - `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0, `prio`=0, scoreboard cleared.
  - `reqN_ready` follows `valid` combinationally; a request in flight when reset asserts is lost, and the requester must re-present it.

## Timing
- `ready` is valid in the same cycle as `valid`.
- A transfer at posedge N drives `rf_wen` high during cycle N+1; the register file commits the write at posedge N+1.
- Throughput is one write per cycle. With both requesters continuously valid, grants alternate 0,1,0,1...
- A read of the target register during cycle N+1 returns the old value; there is no bypass in this block.

## Configuration
- `REG_WB_SCOREBOARD_EN` defined: the busy vector `busy[2**ADDR_WIDTH-1:1]` is built.
  - Set: `alloc_valid && alloc_addr != 0` sets `busy[alloc_addr]` at the posedge.
  - Clear: `rf_wen` clears `busy[rf_waddr]` at the posedge where the write commits.
  - Same address set and cleared at the same edge: set wins, because a newer writer was allocated.
  - `chk_busyK = busy[chk_addrK]`; address 0 always reads 0.
  - An alloc to an already-busy register keeps it busy.
- Not defined: no scoreboard state. `chk_busy1` and `chk_busy2` are tied 0; `alloc_*` inputs are ignored.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle with `rf_wen`=1 -> `rf_wen`, `rf_waddr`, `rf_wdata` go to 0 immediately; after release, `prio`=0.
- Single requester: req0 valid, addr=5, data=0x1234 -> `req0_ready`=1 in the same cycle; next cycle `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0x1234.
- Contention: both valid for 4 cycles (req0 addr=3, req1 addr=7) -> grants req0,req1,req0,req1; `rf_waddr` sequence 3,7,3,7; never both ready.
- x0 write: req1 valid, addr=0, data=0xFFFFFFFF -> `req1_ready`=1; next cycle `rf_wen`=0.
- Scoreboard (macro defined): alloc addr=9 -> `chk_busy1`=1 for `chk_addr1`=9 from the next cycle; req0 writes 9 -> busy clears after the commit edge. Repeat with alloc 9 on the commit edge -> stays busy.
- Scoreboard (macro undefined): alloc addr=9, `chk_addr1`=9 -> `chk_busy1` remains 0.
